// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared BytePipe arbiter constants and FSM state type
package bp_pkg;

  localparam int BP_CMD_WR_BIT = 7;
  localparam int BP_ADDR_W     = 7;
  localparam logic [BP_ADDR_W-1:0] BP_ADDR_BURST = '0;

  typedef enum logic [1:0] {IDLE, CMD, WR, RESP} bp_arb_state_t;

endpackage

// File: rtl/bp_txn_count.sv
// rtl/bp_txn_count.sv - burst mirror and remaining-byte counter for one transaction
// The count saturates at 1 so the single write-response phase needs no reload.
module bp_txn_count
  import bp_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 load_i,
  input  logic [BP_ADDR_W-1:0] addr_i,
  input  logic                 dec_i,
  input  logic                 burst_ld_i,
  input  logic [7:0]           burst_data_i,
  input  logic                 clr_i,
  output logic                 cnt_last_o,
  output logic                 burst_used_o
);

  logic [7:0] burst_q, burst_d;
  logic [8:0] cnt_q, cnt_d;
  logic       used_q, used_d;
  logic       use_burst;

  assign use_burst    = (addr_i != BP_ADDR_BURST) && (burst_q != 8'd0);
  assign cnt_last_o   = (cnt_q == 9'd1);
  assign burst_used_o = used_q;

  always_comb begin
    burst_d = burst_q;
    cnt_d   = cnt_q;
    used_d  = used_q;
    if (load_i) begin
      used_d = use_burst;
      cnt_d  = use_burst ? ({1'b0, burst_q} + 9'd1) : 9'd1;
    end else if (dec_i) begin
      cnt_d = cnt_last_o ? 9'd1 : (cnt_q - 9'd1);
    end
    if (burst_ld_i) begin
      burst_d = burst_data_i;
    end else if (clr_i) begin
      burst_d = 8'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      burst_q <= 8'd0;
      cnt_q   <= 9'd0;
      used_q  <= 1'b0;
    end else begin
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      used_q  <= used_d;
    end
  end

endmodule

// File: rtl/bp_arb2.sv
// rtl/bp_arb2.sv - two-host BytePipe arbiter with transaction framing and burst lock
module bp_arb2
  import bp_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter bit BURST_LOCK  = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [7:0] i_h0_data,
  input  logic       i_h0_valid,
  output logic       o_h0_ready,
  output logic [7:0] o_h0_data,
  output logic       o_h0_valid,
  input  logic       i_h0_ready,
  input  logic [7:0] i_h1_data,
  input  logic       i_h1_valid,
  output logic       o_h1_ready,
  output logic [7:0] o_h1_data,
  output logic       o_h1_valid,
  input  logic       i_h1_ready,
  output logic [7:0] o_bp_data,
  output logic       o_bp_valid,
  input  logic       i_bp_ready,
  input  logic [7:0] i_bp_data,
  input  logic       i_bp_valid,
  output logic       o_bp_ready,
  output logic       o_owner,
  output logic       o_busy
);

  bp_arb_state_t        state_q, state_d;
  logic                 owner_q, owner_d, prio_q, prio_d;
  logic                 lock_q, lock_d, wr_q, wr_d;
  logic [BP_ADDR_W-1:0] addr_q, addr_d;
  logic                 req_open, rsp_open, req_valid, rsp_ready, req_fire, rsp_fire;
  logic [7:0]           req_data;
  logic                 cnt_load, cnt_dec, burst_ld, burst_clr, cnt_last, burst_used;

  assign req_valid = owner_q ? i_h1_valid : i_h0_valid;
  assign req_data  = owner_q ? i_h1_data  : i_h0_data;
  assign rsp_ready = owner_q ? i_h1_ready : i_h0_ready;
  assign req_open  = (state_q == CMD) || (state_q == WR);
  assign rsp_open  = (state_q == RESP);
  assign req_fire  = req_open && req_valid && i_bp_ready;
  assign rsp_fire  = rsp_open && i_bp_valid && rsp_ready;

  // Only the owner ever sees a handshake; everything else is forced to zero.
  assign o_bp_valid = req_open && req_valid;
  assign o_bp_data  = req_open ? req_data : 8'd0;
  assign o_h0_ready = req_open && !owner_q && i_bp_ready;
  assign o_h1_ready = req_open && owner_q && i_bp_ready;
  assign o_bp_ready = rsp_open && rsp_ready;
  assign o_h0_valid = rsp_open && !owner_q && i_bp_valid;
  assign o_h1_valid = rsp_open && owner_q && i_bp_valid;
  assign o_h0_data  = (rsp_open && !owner_q) ? i_bp_data : 8'd0;
  assign o_h1_data  = (rsp_open && owner_q) ? i_bp_data : 8'd0;
  assign o_owner    = owner_q;
  assign o_busy     = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    prio_d    = prio_q;
    lock_d    = lock_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    burst_ld  = 1'b0;
    burst_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_h0_valid || i_h1_valid) begin
          if (i_h0_valid && i_h1_valid) owner_d = ROUND_ROBIN ? prio_q : 1'b0;
          else                          owner_d = i_h1_valid;
          state_d = CMD;
        end
      end
      CMD: begin
        if (req_fire) begin
          cnt_load = 1'b1;
          wr_d     = req_data[BP_CMD_WR_BIT];
          addr_d   = req_data[BP_ADDR_W-1:0];
          lock_d   = 1'b0;
          state_d  = req_data[BP_CMD_WR_BIT] ? WR : RESP;
        end
      end
      WR: begin
        if (req_fire) begin
          cnt_dec  = 1'b1;
          burst_ld = (addr_q == BP_ADDR_BURST);
          if (cnt_last) begin
            burst_clr = burst_used;
            lock_d    = BURST_LOCK && (addr_q == BP_ADDR_BURST);
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_fire) begin
          cnt_dec = 1'b1;
          if (cnt_last) begin
            burst_clr = burst_used && !wr_q;
            // A burst-setup write keeps the same host for its follow-up transaction.
            if (lock_q) begin
              state_d = CMD;
            end else begin
              state_d = IDLE;
              prio_d  = !owner_q;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      lock_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      lock_q  <= lock_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
    end
  end

  bp_txn_count u_cnt (
    .clk_i       (i_clk),
    .rstn_i      (i_rstn),
    .load_i      (cnt_load),
    .addr_i      (req_data[BP_ADDR_W-1:0]),
    .dec_i       (cnt_dec),
    .burst_ld_i  (burst_ld),
    .burst_data_i(req_data),
    .clr_i       (burst_clr),
    .cnt_last_o  (cnt_last),
    .burst_used_o(burst_used)
  );

endmodule

// File: tb/tb_bp_arb2.sv
// tb/tb_bp_arb2.sv - directed bench for bp_arb2 with host/slave byte queues
module tb_bp_arb2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] h0_req_data, h1_req_data, bp_rsp_data;
  logic       h0_req_valid, h1_req_valid, bp_rsp_valid;
  logic       h0_rsp_ready, h1_rsp_ready, bp_req_ready;
  logic       h0_req_ready, h1_req_ready, h0_rsp_valid, h1_rsp_valid;
  logic [7:0] h0_rsp_data, h1_rsp_data, bp_req_data;
  logic       bp_req_valid, bp_rsp_ready, owner, busy;

  logic       fp_h0_valid;
  logic       fp_h0_ready, fp_h0_rvalid, fp_h1_ready, fp_h1_rvalid;
  logic [7:0] fp_h0_rdata, fp_h1_rdata, fp_bp_data;
  logic       fp_bp_valid, fp_bp_ready, fp_owner, fp_busy;
  int         fp_n0 = 0, fp_n1 = 0;

  logic [7:0] h0_q[$], h1_q[$], sr_q[$];
  logic [7:0] sl_log[$], h0_log[$], h1_log[$];
  bit         who_log[$];
  int         viol;
  int         n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  bp_arb2 u_dut (
    .i_clk(clk), .i_rstn(rst_n),
    .i_h0_data(h0_req_data), .i_h0_valid(h0_req_valid), .o_h0_ready(h0_req_ready),
    .o_h0_data(h0_rsp_data), .o_h0_valid(h0_rsp_valid), .i_h0_ready(h0_rsp_ready),
    .i_h1_data(h1_req_data), .i_h1_valid(h1_req_valid), .o_h1_ready(h1_req_ready),
    .o_h1_data(h1_rsp_data), .o_h1_valid(h1_rsp_valid), .i_h1_ready(h1_rsp_ready),
    .o_bp_data(bp_req_data), .o_bp_valid(bp_req_valid), .i_bp_ready(bp_req_ready),
    .i_bp_data(bp_rsp_data), .i_bp_valid(bp_rsp_valid), .o_bp_ready(bp_rsp_ready),
    .o_owner(owner), .o_busy(busy)
  );

  bp_arb2 #(.ROUND_ROBIN(1'b0), .BURST_LOCK(1'b1)) u_fp (
    .i_clk(clk), .i_rstn(rst_n),
    .i_h0_data(8'h01), .i_h0_valid(fp_h0_valid), .o_h0_ready(fp_h0_ready),
    .o_h0_data(fp_h0_rdata), .o_h0_valid(fp_h0_rvalid), .i_h0_ready(1'b1),
    .i_h1_data(8'h02), .i_h1_valid(1'b1), .o_h1_ready(fp_h1_ready),
    .o_h1_data(fp_h1_rdata), .o_h1_valid(fp_h1_rvalid), .i_h1_ready(1'b1),
    .o_bp_data(fp_bp_data), .o_bp_valid(fp_bp_valid), .i_bp_ready(1'b1),
    .i_bp_data(8'hEE), .i_bp_valid(1'b1), .o_bp_ready(fp_bp_ready),
    .o_owner(fp_owner), .o_busy(fp_busy)
  );

  always @(negedge clk) begin
    if (fp_h0_rvalid) fp_n0 <= fp_n0 + 1;
    if (fp_h1_rvalid) fp_n1 <= fp_n1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive();
    h0_req_valid = (h0_q.size() != 0);
    h0_req_data  = (h0_q.size() != 0) ? h0_q[0] : 8'h00;
    h1_req_valid = (h1_q.size() != 0);
    h1_req_data  = (h1_q.size() != 0) ? h1_q[0] : 8'h00;
    bp_rsp_valid = (sr_q.size() != 0);
    bp_rsp_data  = (sr_q.size() != 0) ? sr_q[0] : 8'h00;
  endtask

  task automatic tick();
    bit p0, p1, ps;
    @(negedge clk);
    p0 = h0_req_valid && h0_req_ready;
    p1 = h1_req_valid && h1_req_ready;
    ps = bp_rsp_valid && bp_rsp_ready;
    if (bp_req_valid && bp_req_ready) sl_log.push_back(bp_req_data);
    if (h0_rsp_valid && h0_rsp_ready) begin h0_log.push_back(h0_rsp_data); who_log.push_back(1'b0); end
    if (h1_rsp_valid && h1_rsp_ready) begin h1_log.push_back(h1_rsp_data); who_log.push_back(1'b1); end
    if (!busy && (h0_req_ready || h1_req_ready || h0_rsp_valid || h1_rsp_valid || bp_req_valid || bp_rsp_ready)) viol++;
    if (!owner && (h1_req_ready || h1_rsp_valid)) viol++;
    if (owner && (h0_req_ready || h0_rsp_valid)) viol++;
    @(posedge clk);
    #1;
    if (p0) void'(h0_q.pop_front());
    if (p1) void'(h1_q.pop_front());
    if (ps) void'(sr_q.pop_front());
    drive();
  endtask

  task automatic clr_logs();
    sl_log.delete(); h0_log.delete(); h1_log.delete(); who_log.delete();
    viol = 0;
  endtask

  task automatic wait_done(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      done = (h0_q.size() == 0) && (h1_q.size() == 0) && (sr_q.size() == 0) && !busy;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_viol"}, 32'(viol), 32'd0);
  endtask

  // exp holds the expected bytes left to right, last byte in exp[7:0].
  task automatic chk_log(input string tag, input int sel, input int n, input logic [63:0] exp);
    int sz;
    logic [7:0] b;
    case (sel)
      0:       sz = sl_log.size();
      1:       sz = h0_log.size();
      2:       sz = h1_log.size();
      default: sz = who_log.size();
    endcase
    chk({tag, "_len"}, 32'(sz), 32'(n));
    for (int i = 0; i < n && i < sz; i++) begin
      case (sel)
        0:       b = sl_log[i];
        1:       b = h0_log[i];
        2:       b = h1_log[i];
        default: b = {7'd0, who_log[i]};
      endcase
      chk($sformatf("%s_%0d", tag, i), 32'(b), 32'(exp[8*(n-1-i) +: 8]));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fp_h0_valid = 1'b1;
    h0_rsp_ready = 1'b1; h1_rsp_ready = 1'b1; bp_req_ready = 1'b1;
    viol = 0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_bp_valid", 32'(bp_req_valid), 32'd0);
    rst_n = 1'b1;

    // fixed-priority instance: h0 every third cycle, h1 starved until h0 drops
    repeat (30) tick();
    chk("fp_h0_count", 32'(fp_n0), 32'd10);
    chk("fp_h1_starved", 32'(fp_n1), 32'd0);
    fp_h0_valid = 1'b0;
    repeat (3) tick();
    chk("fp_h1_count", 32'(fp_n1), 32'd1);
    chk("fp_owner", 32'(fp_owner), 32'd1);

    clr_logs();
    h0_q.push_back(8'h05); sr_q.push_back(8'hAB); drive();
    #1;
    chk("rd_bubble_busy", 32'(busy), 32'd0);
    chk("rd_bubble_ready", 32'(h0_req_ready), 32'd0);
    tick();
    chk("rd_grant_busy", 32'(busy), 32'd1);
    chk("rd_grant_bpv", 32'(bp_req_valid), 32'd1);
    chk("rd_grant_bpd", 32'(bp_req_data), 32'h05);
    wait_done("rd");
    chk_log("rd_sl", 0, 1, 64'h05);
    chk_log("rd_h0", 1, 1, 64'hAB);
    chk_log("rd_h1", 2, 0, 64'h0);
    chk("rd_owner", 32'(owner), 32'd0);

    clr_logs();
    h1_q.push_back(8'h89); h1_q.push_back(8'h03); sr_q.push_back(8'h11); drive();
    wait_done("wr");
    chk_log("wr_sl", 0, 2, 64'h89_03);
    chk_log("wr_h1", 2, 1, 64'h11);
    chk_log("wr_h0", 1, 0, 64'h0);
    chk("wr_owner", 32'(owner), 32'd1);

    clr_logs();
    h0_q.push_back(8'h01); h0_q.push_back(8'h02);
    h1_q.push_back(8'h11); h1_q.push_back(8'h12);
    for (int i = 0; i < 4; i++) sr_q.push_back(8'h61 + 8'(i));
    drive();
    wait_done("rr");
    chk_log("rr_who", 3, 4, 64'h00_01_00_01);
    chk_log("rr_sl", 0, 4, 64'h01_11_02_12);
    chk_log("rr_h0", 1, 2, 64'h61_63);
    chk_log("rr_h1", 2, 2, 64'h62_64);

    clr_logs();
    h0_q.push_back(8'h80); h0_q.push_back(8'h03); h0_q.push_back(8'h04);
    h1_q.push_back(8'h06);
    sr_q.push_back(8'h21);
    for (int i = 0; i < 4; i++) sr_q.push_back(8'h31 + 8'(i));
    sr_q.push_back(8'h41);
    drive();
    wait_done("lock");
    chk_log("lock_who", 3, 6, 64'h00_00_00_00_00_01);
    chk_log("lock_sl", 0, 4, 64'h80_03_04_06);
    chk_log("lock_h0", 1, 5, 64'h21_31_32_33_34);
    chk_log("lock_h1", 2, 1, 64'h41);

    clr_logs();
    h0_q.push_back(8'h80); h0_q.push_back(8'h02); h0_q.push_back(8'h8A);
    h0_q.push_back(8'hD0); h0_q.push_back(8'hD1); h0_q.push_back(8'hD2);
    h0_q.push_back(8'h03);
    sr_q.push_back(8'h51); sr_q.push_back(8'h52); sr_q.push_back(8'h53);
    drive();
    wait_done("bwr");
    chk_log("bwr_sl", 0, 7, 64'h80_02_8A_D0_D1_D2_03);
    chk_log("bwr_h0", 1, 3, 64'h51_52_53);

    clr_logs();
    h0_q.push_back(8'h80); h0_q.push_back(8'h01); h0_q.push_back(8'h85);
    sr_q.push_back(8'h71);
    drive();
    for (int i = 0; i < 50 && h0_q.size() != 0; i++) tick();
    chk("arst_setup_sent", 32'(h0_q.size()), 32'd0);
    chk("arst_wr_busy", 32'(busy), 32'd1);
    chk("arst_wr_ready", 32'(h0_req_ready), 32'd1);
    chk_log("arst_sl", 0, 3, 64'h80_01_85);
    chk_log("arst_h0", 1, 1, 64'h71);
    h0_q.push_back(8'hD0); drive();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_owner", 32'(owner), 32'd0);
    chk("arst_bpv", 32'(bp_req_valid), 32'd0);
    chk("arst_bpd", 32'(bp_req_data), 32'd0);
    chk("arst_h0_ready", 32'(h0_req_ready), 32'd0);
    chk("arst_bp_ready", 32'(bp_rsp_ready), 32'd0);
    h0_q.delete(); sr_q.delete(); drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    clr_logs();
    h1_q.push_back(8'h07); sr_q.push_back(8'h5A); drive();
    wait_done("post");
    chk_log("post_sl", 0, 1, 64'h07);
    chk_log("post_h1", 2, 1, 64'h5A);
    chk("post_owner", 32'(owner), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
